fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the 2**PSIZE-deep, WIDTH-bit buffer FIFO between N requesters.
//  - Arbitration is round-robin at packet granularity: a granted requester keeps the port until its req_last beat.
//  - Flow control is credit-based: an internal occupancy counter guarantees no write is issued to a full FIFO.
//  - Sits directly in front of the FIFO write interface; the FIFO read side stays with the consumer.
// PARAMETERS
//  N      4    number of requesters, >=2, power of two
//  WIDTH  512  data beat width, matches FIFO WIDTH
//  PSIZE  2    FIFO pointer width; DEPTH = 2**PSIZE entries
// PORTS
//  clk          in   1          single clock, rising edge
//  rst          in   1          asynchronous, active-high reset
//  req_vld      in   N          requester i has a beat on req_data[i]
//  req_last     in   N          beat of requester i is the last beat of its packet
//  req_data     in   N*WIDTH    requester i beat on slice [i*WIDTH +: WIDTH]
//  req_rdy      out  N          one-hot-or-zero; beat i is accepted when req_vld[i] & req_rdy[i]
//  fifo_wr      out  1          FIFO write strobe (registered)
//  fifo_wdata   out  WIDTH      FIFO write data (registered)
//  fifo_rd      in   1          FIFO pop issued by consumer this cycle (never while empty)
//  credit_cnt   out  PSIZE+1    FIFO occupancy plus in-flight write, 0..DEPTH
//  gnt_id       out  $clog2(N)  current or last granted requester index
//  err_underflow out 1          sticky: fifo_rd seen while credit_cnt==0
// BEHAVIOUR
//  Reset values (async on rst): state=IDLE, rr_ptr=0, owner=0, credit_cnt=0, fifo_wr=0, fifo_wdata=0, gnt_id=0, err_underflow=0.
//  req_rdy is combinational from registered state and req_vld.
//  room = (credit_cnt < DEPTH); req_rdy is all-zero whenever !room.
//  accept = |(req_vld & req_rdy); sel = index of the set req_rdy bit.
//  IDLE:
//   - pick = first i with req_vld[i], searching rr_ptr, rr_ptr+1, ..., wrapping mod N.
//   - If room and any req_vld: req_rdy[pick]=1 and gnt_id<=pick.
//   - If accepted with req_last[pick]=1: stay IDLE, rr_ptr<=pick+1 mod N.
//   - If accepted with req_last[pick]=0: go LOCK, owner<=pick.
//  LOCK:
//   - req_rdy[owner]=room & req_vld[owner]; all other requesters are held off even if valid.
//   - Accept with req_last[owner]=1: go IDLE, rr_ptr<=owner+1 mod N.
//   - The owner dropping req_vld mid-packet keeps LOCK; there is no timeout.
//  Write path (1-cycle latency):
//   - fifo_wr <= accept.
//   - fifo_wdata <= req_data[sel] on accept, otherwise holds its value.
//  Credits:
//   - credit_cnt <= credit_cnt + accept - (fifo_rd & credit_cnt!=0).
//   - accept and fifo_rd in the same cycle leave credit_cnt unchanged.
//   - At credit_cnt==DEPTH with fifo_rd this cycle: no accept (conservative, no same-cycle reuse).
//   - A credit is taken at accept, one cycle before fifo_wr, so the registered write never reaches a full FIFO.
//   - fifo_rd with credit_cnt==0: counter saturates at 0 and err_underflow<=1 (cleared only by rst).
//  Reset mid-packet: all state returns to IDLE/0; the FIFO must be reset in the same cycle (integration rule).
//  rr_ptr advances only at packet end, giving each requester at most one packet per round.
// STRUCTURE
//  Package fifo_arb_pkg:
//   - typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t.
//   - localparam-style helpers: DEPTH = 2**PSIZE, IDW = $clog2(N).
//  Sub-module rr_prio_pick (combinational, N-bit req + IDW-bit base -> one-hot gnt + index).
//   - Implemented as a doubled-vector priority search; reused by other arbiters.
//  Top: state/owner/rr_ptr regs, credit counter, output data register, req_data slice mux.
// TESTING (N=4, PSIZE=2, DEPTH=4)
//  1. rst pulse mid-LOCK with credit_cnt=3 -> next cycle all outputs 0, state IDLE, req_rdy=0 until req_vld.
//  2. req_vld=4'b1111, all last=1, fifo_rd=0 -> grants 0,1,2,3 on successive cycles; credit_cnt 1..4; then req_rdy=0.
//  3. req0 sends a 3-beat packet while req1 valid -> req1 waits 3 beats; req1 granted on cycle 4; rr_ptr=2 after req1.
//  4. Fill to credit_cnt=4, then fifo_rd=1 one cycle -> credit 3, next cycle one grant, fifo_wr 1 cycle later.
//  5. At credit_cnt=2, accept+fifo_rd same cycle -> credit_cnt stays 2; fifo_wdata = granted slice 1 cycle after accept.
//  6. fifo_rd=1 at credit_cnt=0 -> credit_cnt stays 0, err_underflow=1 and stays set until rst.
//  Checks: req_rdy one-hot-or-zero; never fifo_wr while the FIFO is full; credit_cnt <= DEPTH always.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // Arbiter state: IDLE picks a new requester, LOCK holds the port for a packet.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 512;
  localparam int DEF_PSIZE = 2;

  // Number of FIFO entries for a given pointer width.
  function automatic int depth_of(input int psize);
    return 1 << psize;
  endfunction

  // Width of a requester index; at least one bit.
  function automatic int idw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Round-robin priority pick: the first set request at or after 'base',
// wrapping around. N must be a power of two so the index wraps naturally.
module rr_prio_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] base,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate the doubled request vector so 'base' sits at bit 0, then take the
  // lowest set bit; scanning downward lets the lowest hit win.
  always_comb begin
    dbl = {req, req} >> base;
    rot = dbl[N-1:0];
    idx = '0;
    gnt = '0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) idx = base + IDW'(k);
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter for the single write port of a
// 2**PSIZE-deep FIFO, with credit-based flow control so no write ever
// reaches a full FIFO.
//
// Handshake: requester i's beat transfers in a cycle where
// req_vld[i] & req_rdy[i] is high; req_rdy depends on req_vld and registered
// state only, and req_vld/req_data/req_last must be stable while waiting.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N     = DEF_N,
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int PSIZE = DEF_PSIZE,
  localparam int DEPTH = depth_of(PSIZE),
  localparam int IDW   = idw_of(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_vld,
  input  logic [N-1:0]       req_last,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_rdy,
  output logic               fifo_wr,
  output logic [WIDTH-1:0]   fifo_wdata,
  input  logic               fifo_rd,
  output logic [PSIZE:0]     credit_cnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               err_underflow,
  output arb_state_t         dbg_state,
  output logic [IDW-1:0]     dbg_rr_ptr
);

  localparam logic [PSIZE:0] DEPTH_C = (PSIZE + 1)'(DEPTH);

  arb_state_t       state;
  logic [IDW-1:0]   owner;
  logic [IDW-1:0]   rr_ptr;
  logic             room;
  logic             accept;
  logic             rd_dec;
  logic [N-1:0]     pick_gnt;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [IDW-1:0]   sel;
  logic [WIDTH-1:0] sel_data;

  assign room = (credit_cnt < DEPTH_C);

  rr_prio_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req  (req_vld),
    .base (rr_ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Ready generation: round-robin pick in IDLE, only the packet owner in LOCK.
  always_comb begin
    req_rdy = '0;
    sel     = pick_idx;
    if (state == ARB_IDLE) begin
      if (room) req_rdy = pick_gnt;
    end else begin
      sel            = owner;
      req_rdy[owner] = room & req_vld[owner];
    end
  end

  assign accept   = |(req_vld & req_rdy);
  assign sel_data = req_data[sel*WIDTH +: WIDTH];
  assign rd_dec   = fifo_rd && (credit_cnt != '0);

  // Arbitration FSM plus the registered write strobe and data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      gnt_id     <= '0;
      fifo_wr    <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      fifo_wr <= accept;
      if (accept) fifo_wdata <= sel_data;
      case (state)
        ARB_IDLE: begin
          if (room && pick_any) gnt_id <= pick_idx;
          if (accept) begin
            if (req_last[pick_idx]) begin
              rr_ptr <= pick_idx + IDW'(1);
            end else begin
              state <= ARB_LOCK;
              owner <= pick_idx;
            end
          end
        end
        ARB_LOCK: begin
          if (accept && req_last[owner]) begin
            state  <= ARB_IDLE;
            rr_ptr <= owner + IDW'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Credit counter: a credit is taken at accept, returned at each real pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt    <= '0;
      err_underflow <= 1'b0;
    end else begin
      credit_cnt <= credit_cnt + {{PSIZE{1'b0}}, accept} - {{PSIZE{1'b0}}, rd_dec};
      if (fifo_rd && (credit_cnt == '0)) err_underflow <= 1'b1;
    end
  end

  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

endmodule
